fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter XLEN, default 32, the address and instruction width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  read data valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 stall  input  1  the decode/execute consumer cannot accept the presented instruction.
REQ-011 PCSrc  input  1  taken branch/jump for the presented instruction.
REQ-012 PCTarget  input  32  branch/jump target for the presented instruction.
REQ-013 instr_valid  output  1  instr and its decoded fields are valid.
REQ-014 instr  output  32  held instruction word.
REQ-015 op  output  7  instr[6:0].
REQ-016 funct3  output  3  instr[14:12].
REQ-017 funct7  output  1  instr[30].
REQ-018 pc  output  32  address of the presented instruction.
REQ-019 pc_plus4  output  32  pc+4, modulo 2^32.
REQ-020 instr_illegal  output  1  asserted with instr_valid when instr[1:0]!=2'b11; compressed encodings are unsupported.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, WAIT and HOLD.
REQ-022 IDLE SHALL last exactly one cycle after reset deassertion, then move to REQ with fetch address RESET_PC.
REQ-023 In REQ, imem_req SHALL be 1; imem_addr SHALL stay stable until imem_req & imem_ready.
REQ-024 On imem_req & imem_ready, the FSM SHALL move to WAIT, with at most one outstanding request.
REQ-025 In WAIT, imem_rvalid SHALL capture imem_rdata into instr, set instr_valid=1 next cycle and move to HOLD.
REQ-026 imem_rvalid in the same cycle as acceptance SHALL be ignored; data is accepted only in WAIT.
REQ-027 In HOLD, instr, pc and all fields SHALL remain stable while stall=1.
REQ-028 An instruction is consumed in a HOLD cycle with instr_valid & !stall.
REQ-029 On consumption, the next fetch address SHALL be {PCTarget[31:2],2'b00} if PCSrc=1, else pc_plus4.
REQ-030 On consumption, instr_valid SHALL drop next cycle and the FSM SHALL move to REQ.
REQ-031 PCSrc and PCTarget SHALL be ignored in every cycle except a consumption cycle.
REQ-032 Minimum throughput: one instruction per 3 cycles, with imem_ready=1 and rvalid one cycle after acceptance.
REQ-033 The PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-034 imem_rvalid outside WAIT SHALL be discarded without a state change.

Reset
REQ-035 On rst=1, asynchronously: state=IDLE, imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), pc=RESET_PC, instr_illegal=0.
REQ-036 Reset asserted mid-transaction (REQ/WAIT/HOLD) SHALL abandon the outstanding request; a late rvalid after release SHALL be ignored per REQ-034.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, RESET_PC default, NOP constant and field bit-position constants.
REQ-038 One sub-module, pc_next_logic (combinational next-PC select and alignment), SHALL be instantiated; all else lives in fetch_unit.

Verification
REQ-039 Reset, imem_ready=1, rvalid one cycle later, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8 with instr_valid pulses 3 cycles apart.
REQ-040 stall=1 for 5 cycles in HOLD with instr=0x00A00093 -> instr, pc=0x4, op=7'h13 stable; no imem_req until stall falls.
REQ-041 Consumption with PCSrc=1, PCTarget=0x102 -> next imem_addr=0x100; PCSrc=1 outside HOLD -> no effect.
REQ-042 imem_ready low 4 cycles -> imem_req held and imem_addr unchanged; rvalid injected in REQ -> ignored.
REQ-043 rst asserted in WAIT, rvalid 2 cycles after release -> instr_valid=0, first fetch at RESET_PC.
REQ-044 rdata=0x00004501 (compressed) -> instr_illegal=1 with instr_valid; pc=0xFFFFFFFC consumed -> next imem_addr=0x0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM states, reset defaults and instruction field positions for the fetch unit
package fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_BIT = 30;
endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next_logic: sequential/branch next-PC select with word alignment of branch targets
module pc_next_logic #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
);
  assign pc_plus4 = pc + XLEN'(4);
  assign next_pc = pcsrc ? target & ~XLEN'(3) : pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a hold register presented to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_illegal
);
  state_t state, state_n;
  logic [XLEN-1:0] addr, next_pc;
  logic capture, consume;
  pc_next_logic #(.XLEN(XLEN)) u_pc_next (
    .pc(pc),
    .pcsrc(PCSrc),
    .target(PCTarget),
    .pc_plus4(pc_plus4),
    .next_pc(next_pc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    capture = state == WAIT && imem_rvalid;
    consume = state == HOLD && !stall;
    state_n = state == IDLE ? REQ :
              state == REQ && imem_ready ? WAIT :
              capture ? HOLD :
              consume ? REQ : state;
  end
  // addr is the pending fetch address; pc only changes when a word actually arrives
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr  <= RESET_PC & ~XLEN'(3);
      instr <= XLEN'(NOP);
      pc    <= RESET_PC;
    end else begin
      if (capture) begin
        instr <= imem_rdata;
        pc    <= addr;
      end
      if (consume) addr <= next_pc;
    end
  assign imem_req = state == REQ;
  assign imem_addr = addr;
  assign instr_valid = state == HOLD;
  assign op = instr[OP_MSB:OP_LSB];
  assign funct3 = instr[F3_MSB:F3_LSB];
  assign funct7 = instr[F7_BIT];
  assign instr_illegal = instr_valid && instr[1:0] != 2'b11;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench driving a memory responder and decode-side stall/branch controls
module tb_fetch_unit;
  logic        clk = 0, rst = 1;
  logic        imem_req, imem_ready = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic        stall = 0, PCSrc = 0;
  logic [31:0] PCTarget = 0;
  logic        instr_valid, funct7, instr_illegal;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  int checks = 0, errors = 0, cyc = 0, t0;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
  exp_t sb[$];

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(instr_valid), .instr(instr), .op(op), .funct3(funct3),
    .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4), .instr_illegal(instr_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deliver();
    exp_t e;
    check("valid", 32'(instr_valid), 1);
    check("sb_size", 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("instr", instr, e.instr);
      check("pc", pc, e.pc);
      check("pc_plus4", pc_plus4, e.pc + 32'd4);
      check("op", 32'(op), 32'(e.instr[6:0]));
      check("funct3", 32'(funct3), 32'(e.instr[14:12]));
      check("funct7", 32'(funct7), 32'(e.instr[30]));
      check("illegal", 32'(instr_illegal), 32'(e.instr[1:0] != 2'b11));
    end
  endtask

  // serve one fetch: optional ready backpressure with stray rvalid, then data one cycle after acceptance
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int rdelay);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(imem_req), 1);
    check("addr", imem_addr, addr);
    for (int i = 0; i < rdelay; i++) begin
      imem_rvalid = 1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      check("req_hold", 32'(imem_req), 1);
      check("addr_hold", imem_addr, addr);
      check("no_valid", 32'(instr_valid), 0);
    end
    imem_ready = 1;
    tick();
    imem_ready = 0;
    sb.push_back({addr, data});
    imem_rvalid = 1;
    imem_rdata = data;
    tick();
    imem_rvalid = 0;
    imem_rdata = 0;
    deliver();
  endtask

  initial begin
    tick();
    tick();
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    check("rst_illegal", 32'(instr_illegal), 0);
    rst = 0;
    check("idle_req", 32'(imem_req), 0);
    tick();
    check("idle_1cyc", 32'(imem_req), 1);
    fetch(32'h0, 32'h0000_0013, 0);
    t0 = cyc;
    fetch(32'h4, 32'h00A0_0093, 0);
    check("spacing_0_4", 32'(cyc - t0), 3);
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      PCSrc = 1;
      PCTarget = 32'h700;
      tick();
      check("stall_instr", instr, 32'h00A0_0093);
      check("stall_pc", pc, 32'h4);
      check("stall_op", 32'(op), 32'h13);
      check("stall_req", 32'(imem_req), 0);
      check("stall_valid", 32'(instr_valid), 1);
    end
    PCSrc = 0;
    stall = 0;
    fetch(32'h8, 32'h0020_8133, 0);
    PCSrc = 1;
    PCTarget = 32'h102;
    tick();
    PCTarget = 32'h500;
    fetch(32'h100, 32'h4000_0033, 0);
    PCSrc = 0;
    t0 = cyc;
    fetch(32'h104, 32'h0000_5013, 0);
    check("spacing_100_104", 32'(cyc - t0), 3);
    fetch(32'h108, 32'h0041_0193, 4);
    fetch(32'h10C, 32'h0000_4501, 0);
    PCSrc = 1;
    PCTarget = 32'hFFFF_FFFC;
    tick();
    PCSrc = 0;
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
    fetch(32'h0, 32'h0000_0093, 0);
    tick();
    while (!imem_req) tick();
    imem_ready = 1;
    tick();
    imem_ready = 0;
    rst = 1;
    #1;
    check("arst_valid", 32'(instr_valid), 0);
    check("arst_req", 32'(imem_req), 0);
    check("arst_pc", pc, 32'h0);
    tick();
    rst = 0;
    tick();
    tick();
    imem_rvalid = 1;
    imem_rdata = 32'hBAD0_0013;
    tick();
    imem_rvalid = 0;
    check("late_valid", 32'(instr_valid), 0);
    check("late_instr", instr, 32'h0000_0013);
    fetch(32'h0, 32'h0010_0113, 0);
    check("sb_left", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
